// File: rtl/muldiv_unit_if.sv
// ============================================================================
//  Module      : muldiv_unit_if
//  Description : Issue / result bundle between the EX-stage decoder and the
//                multiply/divide unit holding HI/LO.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface muldiv_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    // Decoder / pipeline side
    modport master (
        output start, op, src_a, src_b, mthi, mtlo, wdata, flush,
        input  busy, done, hi, lo
    );

    // Multiply/divide unit side
    modport slave (
        input  start, op, src_a, src_b, mthi, mtlo, wdata, flush,
        output busy, done, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
//  Module      : muldiv_unit
//  Description : Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO
//                registers, MTHI/MTLO writes, flush abort and busy/done status.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int MUL_CYCLES = 4            // multiply latency, 1..8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    muldiv_unit_if.slave    bus
);

    // 32 restoring iterations followed by one sign-fixup cycle
    localparam int DIV_ITERS = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q,   cnt_d;
    logic        sgn_q,   sgn_d;    // signed variant (MULT / DIV)
    logic [31:0] a_q,     a_d;      // multiplicand, or dividend/quotient shift reg
    logic [31:0] b_q,     b_d;      // multiplier, or divisor magnitude
    logic [31:0] rem_q,   rem_d;    // partial remainder
    logic        qneg_q,  qneg_d;   // quotient must be negated
    logic        rneg_q,  rneg_d;   // remainder must be negated
    logic        div0_q,  div0_d;   // divisor was zero: leave HI/LO alone
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;

    logic [63:0] w_a64;
    logic [63:0] w_b64;
    logic [63:0] w_prod;
    logic [32:0] w_trial;
    logic        w_a_neg;
    logic        w_b_neg;

    // Operands are sign- or zero-extended to 64 bits so one multiplier
    // serves both MULT and MULTU; the low 64 bits are the exact product.
    assign w_a64  = {{32{sgn_q & a_q[31]}}, a_q};
    assign w_b64  = {{32{sgn_q & b_q[31]}}, b_q};
    assign w_prod = w_a64 * w_b64;

    // Trial subtraction of one restoring-division step
    assign w_trial = {rem_q, a_q[31]} - {1'b0, b_q};

    // Operand signs at issue time (only meaningful for DIV)
    assign w_a_neg = ~bus.op[0] & bus.src_a[31];
    assign w_b_neg = ~bus.op[0] & bus.src_b[31];

    // Next-state logic: issue, multiply countdown, divide iterations, fixup,
    // MTHI/MTLO writes, and flush overriding everything else.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        div0_d  = div0_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    sgn_d  = ~bus.op[0];
                    busy_d = 1'b1;
                    if (!bus.op[1]) begin
                        state_d = ST_MUL;
                        cnt_d   = 6'(MUL_CYCLES);
                        a_d     = bus.src_a;
                        b_d     = bus.src_b;
                    end else begin
                        state_d = ST_DIV;
                        cnt_d   = 6'(DIV_ITERS);
                        a_d     = w_a_neg ? -bus.src_a : bus.src_a;
                        b_d     = w_b_neg ? -bus.src_b : bus.src_b;
                        rem_d   = 32'd0;
                        qneg_d  = w_a_neg ^ w_b_neg;
                        rneg_d  = w_a_neg;
                        div0_d  = (bus.src_b == 32'd0);
                    end
                end else begin
                    if (bus.mthi) hi_d = bus.wdata;
                    if (bus.mtlo) lo_d = bus.wdata;
                end
            end

            ST_MUL: begin
                if (cnt_q == 6'd1) begin
                    hi_d    = w_prod[63:32];
                    lo_d    = w_prod[31:0];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = 6'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end

            ST_DIV: begin
                if (!w_trial[32]) begin
                    rem_d = w_trial[31:0];
                    a_d   = {a_q[30:0], 1'b1};
                end else begin
                    rem_d = {rem_q[30:0], a_q[31]};
                    a_d   = {a_q[30:0], 1'b0};
                end
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = ST_FIX;
                end
            end

            default: begin  // ST_FIX
                if (!div0_q) begin
                    lo_d = qneg_q ? -a_q   : a_q;
                    hi_d = rneg_q ? -rem_q : rem_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = 6'd0;
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over issue, completion and MTHI/MTLO alike
        if (bus.flush) begin
            state_d = ST_IDLE;
            cnt_d   = 6'd0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State and architectural registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 6'd0;
            sgn_q   <= 1'b0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            rem_q   <= 32'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            div0_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            div0_q  <= div0_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Directed self-checking bench for muldiv_unit.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    int   failed;

    muldiv_unit_if bus ();

    muldiv_unit #(.MUL_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock: through the rising edge to the following falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        tick();
        bus.start = 1'b0;
    endtask

    // Count busy cycles (bounded), then expect the done pulse
    task automatic run(input string tag, input int cycles);
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check({tag, " busy cycles"}, 64'(n), 64'(cycles));
        check({tag, " done"}, 64'(bus.done), 64'd1);
    endtask

    initial begin
        int seen_done;
        total  = 0;
        passed = 0;
        failed = 0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.src_a = 32'd0;
        bus.src_b = 32'd0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wdata = 32'd0;
        bus.flush = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset hi",   64'(bus.hi),   64'd0);
        check("reset lo",   64'(bus.lo),   64'd0);
        rst_n = 1'b1;
        tick();

        // MULT -3 * 5 = -15
        issue(2'b00, 32'hFFFF_FFFD, 32'd5);
        run("mult", 4);
        check("mult hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check("mult lo", 64'(bus.lo), 64'hFFFF_FFF1);
        tick();
        check("mult done one cycle", 64'(bus.done), 64'd0);

        // MULTU 0xFFFFFFFF^2
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run("multu", 4);
        check("multu hi", 64'(bus.hi), 64'hFFFF_FFFE);
        check("multu lo", 64'(bus.lo), 64'h0000_0001);

        // DIV -7 / 2 = -3 rem -1
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        run("div", 33);
        check("div lo", 64'(bus.lo), 64'hFFFF_FFFD);
        check("div hi", 64'(bus.hi), 64'hFFFF_FFFF);

        // Signed overflow
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run("div ovf", 33);
        check("div ovf lo", 64'(bus.lo), 64'h8000_0000);
        check("div ovf hi", 64'(bus.hi), 64'h0);

        // Preload HI/LO
        bus.mthi = 1'b1; bus.wdata = 32'h11; tick(); bus.mthi = 1'b0;
        bus.mtlo = 1'b1; bus.wdata = 32'h22; tick(); bus.mtlo = 1'b0;
        check("mthi", 64'(bus.hi), 64'h11);
        check("mtlo", 64'(bus.lo), 64'h22);

        // DIVU by zero: full latency, done, HI/LO untouched
        issue(2'b11, 32'd100, 32'd0);
        run("divu0", 33);
        check("divu0 hi", 64'(bus.hi), 64'h11);
        check("divu0 lo", 64'(bus.lo), 64'h22);

        // DIVU 100/7 flushed at cycle 10, with an ignored start while busy
        issue(2'b11, 32'd100, 32'd7);
        repeat (3) tick();
        bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'd3; bus.src_b = 32'd4;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        check("flush busy before", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush busy", 64'(bus.busy), 64'd0);
        check("flush done", 64'(bus.done), 64'd0);
        check("flush hi", 64'(bus.hi), 64'h11);
        check("flush lo", 64'(bus.lo), 64'h22);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
        end
        check("flush stays idle", 64'(seen_done), 64'd0);

        // start + mthi in one cycle: issue wins, HI not written
        bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'd3; bus.src_b = 32'd4;
        bus.mthi  = 1'b1; bus.wdata = 32'h55;
        tick();
        bus.start = 1'b0; bus.mthi = 1'b0;
        check("start+mthi busy", 64'(bus.busy), 64'd1);
        check("start+mthi hi", 64'(bus.hi), 64'h11);
        run("multu 3x4", 4);
        check("multu 3x4 lo", 64'(bus.lo), 64'd12);
        check("multu 3x4 hi", 64'(bus.hi), 64'd0);

        // Back-to-back: DIVU issued on the done cycle
        issue(2'b11, 32'd13, 32'd4);
        check("b2b busy", 64'(bus.busy), 64'd1);
        run("divu 13/4", 33);
        check("divu 13/4 lo", 64'(bus.lo), 64'd3);
        check("divu 13/4 hi", 64'(bus.hi), 64'd1);

        // Asynchronous reset in the middle of a MULT
        issue(2'b00, 32'd7, 32'd7);
        tick();
        rst_n = 1'b0;
        #1;
        check("async rst busy", 64'(bus.busy), 64'd0);
        check("async rst done", 64'(bus.done), 64'd0);
        check("async rst hi",   64'(bus.hi),   64'd0);
        check("async rst lo",   64'(bus.lo),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post rst busy", 64'(bus.busy), 64'd0);
        bus.mthi = 1'b1; bus.wdata = 32'hDEAD_BEEF;
        tick();
        bus.mthi = 1'b0;
        check("mthi after rst", 64'(bus.hi), 64'hDEAD_BEEF);
        check("lo after mthi", 64'(bus.lo), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit with the architectural HI/LO registers, sitting in the EX stage directly downstream of the instruction decoder. It consumes MULT/MULTU/DIV/DIVU (RegDst = PROD) and MTHI/MTLO (RegDst = HI/LO) and holds the HI/LO values that MFHI/MFLO read. It raises `busy` so the hazard unit can stall dependent instructions while an operation is in flight.

## Interface
- `MUL_CYCLES`, 4: multiply latency in cycles, legal range 1..8.
- `DIV_CYCLES`, 33 (fixed, not overridable): 32 restoring iterations plus 1 sign-fixup cycle.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue a mul/div operation this cycle.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src_a`  in  32  GPR[rs] (multiplicand or dividend).
- `src_b`  in  32  GPR[rt] (multiplier or divisor).
- `mthi`  in  1  write `wdata` to HI.
- `mtlo`  in  1  write `wdata` to LO.
- `wdata`  in  32  data for MTHI/MTLO.
- `flush`  in  1  abort any in-flight operation (exception/ERET).
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse on the cycle HI/LO take a result.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, MUL, DIV, FIX. Reset: IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0.
- IDLE with `start`=1: latch `op`, `src_a`, `src_b`, load the counter, and go to MUL (op 0x) or DIV (op 1x). `start` while `busy`=1 is ignored.
- MUL:
  - Compute the 64-bit product from the latched operands; signed for MULT, unsigned for MULTU.
  - The counter runs MUL_CYCLES down to 1.
  - On the last cycle, write {HI,LO} = product, pulse `done`, return to IDLE.
- DIV:
  - Operate on magnitudes (DIV) or raw values (DIVU).
  - Run 32 restoring shift-subtract iterations, one per cycle, then go to FIX.
- FIX:
  - Apply signs: the quotient is negated if operand signs differ (DIV only); the remainder takes the sign of the dividend.
  - Write LO = quotient, HI = remainder, pulse `done`, return to IDLE.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0. No trap.
- Divide by zero (divisor latched = 0):
  - Full DIV_CYCLES latency.
  - HI/LO are not written.
  - `done` still pulses.
- MTHI/MTLO:
  - Write on the clock edge, only in IDLE with `start`=0.
  - Ignored while `busy`=1 or when `start`=1 in the same cycle (`start` wins).
  - MTHI and MTLO may both be asserted in one cycle; both registers are written.
- `flush` (any state):
  - Next state is IDLE; `busy`=0 the next cycle.
  - No `done`; HI/LO keep their pre-operation values.
  - `flush` and `start` in the same cycle: `flush` wins, nothing is issued.
- `rst_n` low mid-operation: all state and outputs go to reset values immediately (asynchronous).

## Timing
- `start` sampled high at edge E0.
- `busy`=1 from E0 up to the completion edge.
- MUL:
  - Completion edge is E(MUL_CYCLES).
  - `busy` is high for exactly MUL_CYCLES cycles.
  - `done`=1 in the cycle after the completion edge, together with the new `hi`/`lo`.
- DIV: as MUL with DIV_CYCLES = 33.
- `hi`/`lo` are registered outputs; they change only at the completion edge or at an MTHI/MTLO edge.
- Back-to-back: a new `start` is accepted in the same cycle `done`=1 (`busy` is already 0).
- `busy` is a registered output with no combinational path from `start`. The hazard unit must stall MFHI/MFLO/MTHI/MTLO and mul/div instructions on `busy` and on the issue cycle.

## Test plan
- MULT, `src_a`=0xFFFFFFFD (-3), `src_b`=5 -> `busy` high 4 cycles, then `done`, HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. DIV -7/2 -> after 33 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 100/0 with HI=0x11, LO=0x22 preloaded via MTHI/MTLO -> `done` after 33 cycles, HI=0x11, LO=0x22.
- DIVU 100/7 with `flush` at cycle 10 -> `busy` drops next cycle, no `done`, HI/LO unchanged. A second `start` during `busy` is ignored; `start`+`mthi` in the same IDLE cycle -> HI not written, operation issued.
- `rst_n` asserted mid-MULT (cycle 2) -> immediately `busy`=0, `done`=0, `hi`=`lo`=0. After release, MTHI 0xDEADBEEF -> `hi`=0xDEADBEEF the next cycle.
- Back-to-back MULTU 3×4 then DIVU 13/4 issued on the `done` cycle -> LO=12, HI=0 first; then LO=3, HI=1.
